rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Parametrised N-way, W-bit registered multiplexer with built-in arbitration and valid/ready handshaking on every channel and on the output. It is the sequential successor to the fixed 4:1 one-bit gate-level mux. It sits wherever several producers share one downstream port, for example functional units driving the common data bus. Each cycle it selects at most one valid input, either round-robin or fixed-priority, and registers the chosen data together with its channel index.

## Interface

Parameters:
- `WIDTH`, 64, data width in bits (≥1).
- `CHANNELS`, 4, number of input channels (≥2, need not be a power of two).
- `ROUND_ROBIN`, 1, selects the arbitration mode: 1 = round-robin, 0 = fixed priority with the lowest index winning.
- `CW` (localparam), max(1, $clog2(CHANNELS)), width of the channel index.

Ports:
- `clk`  input  1  sole clock; all state is updated on its rising edge.
- `reset`  input  1  synchronous, active-low reset; `reset`=0 at a rising edge resets all state.
- `in_valid`  input  CHANNELS  bit i high = channel i presents data.
- `in_data`  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  output  CHANNELS  one-hot or zero; bit i high = channel i is transferred this cycle.
- `out_valid`  output  1  `out_data` and `out_ch` hold a valid beat.
- `out_data`  output  WIDTH  registered data of the selected channel.
- `out_ch`  output  CW  registered index of the channel that supplied `out_data`.
- `out_ready`  input  1  the consumer accepts the output beat.

## Operation

- State: output register (`out_valid`, `out_data`, `out_ch`) and a round-robin pointer `ptr` (CW bits, range 0..CHANNELS-1).
- `accept` = !`out_valid` | `out_ready`. The output slot is free or is being drained this cycle.
- Grant, round-robin mode: the first channel with `in_valid` high, searching `ptr`, `ptr`+1, … and wrapping modulo CHANNELS.
- Grant, fixed mode: the lowest-index channel with `in_valid` high. `ptr` stays at 0.
- `in_ready[g]` = `accept` & `in_valid[g]` for the granted channel g. All other bits are 0. If no input is valid, `in_ready` = 0.
- Transfer when `in_ready[g]` is high: at the clock edge, `out_data` ← data of g, `out_ch` ← g, `out_valid` ← 1. In round-robin mode, `ptr` ← (g+1) mod CHANNELS, with the wrap computed explicitly for non-power-of-two CHANNELS.
- Output drained with no new transfer (`out_valid` & `out_ready` and no input valid): `out_valid` ← 0. `out_data` and `out_ch` keep their old values.
- Stall (`out_valid` & !`out_ready`): the output register and `ptr` hold, and `in_ready` = 0.
- The arbiter does not lock a grant. A channel that drops `in_valid` before being granted is simply skipped.
- Fairness: in round-robin mode, a continuously valid channel is granted within CHANNELS transfers.
- Reset: `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0, and `in_ready` is forced to 0 while `reset`=0. A beat held in the output register when reset is asserted is discarded.

## Timing

- Latency is 1 cycle from the input transfer edge to `out_valid`/`out_data` being visible.
- Throughput is 1 beat per cycle when `out_ready` is held high. Back-to-back transfers are allowed because the output register drains and refills in the same edge.
- Combinational paths: `in_valid` → `in_ready`, and `out_ready` → `in_ready`. There is no combinational path from any input to `out_valid`, `out_data` or `out_ch`.
- Producers must hold `in_valid` and `in_data` stable until `in_ready` is sampled high. `in_valid` must not depend combinationally on `in_ready`.
- `out_data` and `out_ch` are stable whenever `out_valid` & !`out_ready`.

## Test plan

- Reset and idle (WIDTH=8, CHANNELS=4): hold `reset`=0 for 2 cycles, then `in_valid`=0 → `out_valid`=0, `out_data`=0, `out_ch`=0, `in_ready`=0000 on every cycle.
- Round-robin rotation: all four channels valid with data 0x10/0x11/0x12/0x13 and `out_ready`=1 → `out_ch` sequence 0,1,2,3,0 on consecutive cycles, with `in_ready` one-hot rotating 0001→0010→0100→1000.
- Backpressure: a beat is loaded, then `out_ready`=0 for 3 cycles → `out_data` stays constant, `in_ready`=0000 and `ptr` is unchanged. On the first cycle after `out_ready` returns to 1, the next grant goes to the channel after the held beat's channel.
- Sparse and wrap case: after a grant to ch3, only ch1 and ch2 are valid → ch1 is granted (pointer wrapped to 0 and skipped the idle ch0), then ch2.
- Fixed mode (ROUND_ROBIN=0): ch1 and ch3 continuously valid → `out_ch`=1 every cycle, and ch3 is never granted until ch1 deasserts.
- Reset mid-operation and non-power-of-two: CHANNELS=3 with a beat pending under `out_ready`=0; assert `reset`=0 for one edge → `out_valid`=0 and `ptr`=0. Afterwards, with all channels valid, `out_ch` cycles 0,1,2,0 and the pointer never reaches 3.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-way registered mux with round-robin or fixed-priority arbitration and valid/ready handshake
module rr_mux_arbiter #(
  parameter int WIDTH = 64,
  parameter int CHANNELS = 4,
  parameter bit ROUND_ROBIN = 1,
  localparam int CW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_ch,
  input  logic                      out_ready
);
  logic [CW-1:0] ptr, gnt, ptr_nxt;
  logic hit, accept, xfer;
  int j;
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    j = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      j = int'(ptr) + k;
      j = (j >= CHANNELS) ? j - CHANNELS : j;
      if (!hit && 1'(in_valid >> j)) begin
        hit = 1'b1;
        gnt = CW'(j);
      end
    end
  end
  assign accept = !out_valid || out_ready;
  assign in_ready = (reset && accept && hit) ? CHANNELS'(1) << gnt : '0;
  assign xfer = |in_ready;
  assign ptr_nxt = (int'(gnt) == CHANNELS - 1) ? '0 : gnt + CW'(1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= WIDTH'(in_data >> (int'(gnt) * WIDTH));
      out_ch <= gnt;
      ptr <= ROUND_ROBIN ? ptr_nxt : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench for round-robin, fixed-priority and 3-channel arbiter instances
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  logic       a_reset, a_out_valid, a_out_ready;
  logic [3:0] a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic [7:0] a_out_data;
  logic [1:0] a_out_ch;
  logic       b_reset, b_out_valid, b_out_ready;
  logic [3:0] b_in_valid, b_in_ready;
  logic [31:0] b_in_data;
  logic [7:0] b_out_data;
  logic [1:0] b_out_ch;
  logic       c_reset, c_out_valid, c_out_ready;
  logic [2:0] c_in_valid, c_in_ready;
  logic [23:0] c_in_data;
  logic [7:0] c_out_data;
  logic [1:0] c_out_ch;
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [9:0] qc[$];
  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .ROUND_ROBIN(1)) dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch), .out_ready(a_out_ready));
  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(4), .ROUND_ROBIN(0)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch), .out_ready(b_out_ready));
  rr_mux_arbiter #(.WIDTH(8), .CHANNELS(3), .ROUND_ROBIN(1)) dut_c (
    .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ch(c_out_ch), .out_ready(c_out_ready));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_beat: unexpected ch %0d data %0h, expected no beat", a_out_ch, a_out_data);
      end else chk("a_beat", {a_out_ch, a_out_data}, qa.pop_front());
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_beat: unexpected ch %0d data %0h, expected no beat", b_out_ch, b_out_data);
      end else chk("b_beat", {b_out_ch, b_out_data}, qb.pop_front());
    end
    if (c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL c_beat: unexpected ch %0d data %0h, expected no beat", c_out_ch, c_out_data);
      end else chk("c_beat", {c_out_ch, c_out_data}, qc.pop_front());
    end
  end
  initial begin
    a_reset = 1'b0; a_in_valid = '0; a_in_data = '0; a_out_ready = 1'b1;
    b_reset = 1'b0; b_in_valid = '0; b_in_data = '0; b_out_ready = 1'b1;
    c_reset = 1'b0; c_in_valid = '0; c_in_data = '0; c_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      a_in_valid = (i == 1) ? 4'hF : 4'h0;
      #1;
      chk("a_rst_in_ready", a_in_ready, 4'b0000);
      chk("a_rst_out_valid", a_out_valid, 1'b0);
    end
    step();
    a_reset = 1'b1;
    a_in_valid = 4'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("a_idle_out_valid", a_out_valid, 1'b0);
      chk("a_idle_out_data", a_out_data, 8'h00);
      chk("a_idle_out_ch", a_out_ch, 2'd0);
      chk("a_idle_in_ready", a_in_ready, 4'b0000);
      step();
    end
    a_in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    a_in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("a_rr_in_ready", a_in_ready, 4'b0001 << (i % 4));
      qa.push_back({2'(i % 4), 8'(8'h10 + i % 4)});
      step();
    end
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("a_stall_in_ready", a_in_ready, 4'b0000);
      chk("a_stall_out_valid", a_out_valid, 1'b1);
      chk("a_stall_out_data", a_out_data, 8'h10);
      chk("a_stall_out_ch", a_out_ch, 2'd0);
      step();
    end
    a_out_ready = 1'b1;
    #1;
    chk("a_resume_in_ready", a_in_ready, 4'b0010);
    qa.push_back({2'd1, 8'h11});
    step();
    a_in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_in_valid = 4'b1000;
    #1;
    chk("a_ch3_in_ready", a_in_ready, 4'b1000);
    qa.push_back({2'd3, 8'hA3});
    step();
    a_in_valid = 4'b0110;
    #1;
    chk("a_wrap_in_ready", a_in_ready, 4'b0010);
    qa.push_back({2'd1, 8'hA1});
    step();
    #1;
    chk("a_sparse_in_ready", a_in_ready, 4'b0100);
    qa.push_back({2'd2, 8'hA2});
    step();
    a_in_valid = 4'b0000;
    #1;
    chk("a_noin_in_ready", a_in_ready, 4'b0000);
    chk("a_last_out_valid", a_out_valid, 1'b1);
    step();
    #1;
    chk("a_drain_out_valid", a_out_valid, 1'b0);
    chk("a_drain_out_data", a_out_data, 8'hA2);
    chk("a_drain_out_ch", a_out_ch, 2'd2);
    step();
    chk("a_queue_empty", qa.size(), 0);
    b_in_data = {8'h43, 8'h42, 8'h41, 8'h40};
    b_in_valid = 4'b1010;
    #1;
    chk("b_rst_in_ready", b_in_ready, 4'b0000);
    chk("b_rst_out_valid", b_out_valid, 1'b0);
    step();
    b_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b_fixed_in_ready", b_in_ready, 4'b0010);
      qb.push_back({2'd1, 8'h41});
      step();
    end
    b_in_valid = 4'b1000;
    #1;
    chk("b_ch3_in_ready", b_in_ready, 4'b1000);
    qb.push_back({2'd3, 8'h43});
    step();
    b_in_valid = 4'b1001;
    #1;
    chk("b_low_in_ready", b_in_ready, 4'b0001);
    qb.push_back({2'd0, 8'h40});
    step();
    b_in_valid = 4'b0000;
    #1;
    chk("b_noin_in_ready", b_in_ready, 4'b0000);
    step();
    step();
    chk("b_queue_empty", qb.size(), 0);
    c_reset = 1'b1;
    c_in_data = {8'h22, 8'h21, 8'h20};
    c_in_valid = 3'b111;
    #1;
    chk("c_first_in_ready", c_in_ready, 3'b001);
    qc.push_back({2'd0, 8'h20});
    step();
    #1;
    chk("c_second_in_ready", c_in_ready, 3'b010);
    step();
    c_out_ready = 1'b0;
    #1;
    chk("c_pend_in_ready", c_in_ready, 3'b000);
    chk("c_pend_out_valid", c_out_valid, 1'b1);
    chk("c_pend_out_ch", c_out_ch, 2'd1);
    c_reset = 1'b0;
    step();
    c_reset = 1'b1;
    #1;
    chk("c_rst_out_valid", c_out_valid, 1'b0);
    chk("c_rst_out_ch", c_out_ch, 2'd0);
    chk("c_rst_out_data", c_out_data, 8'h00);
    c_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("c_rr_in_ready", c_in_ready, 3'b001 << (i % 3));
      qc.push_back({2'(i % 3), 8'(8'h20 + i % 3)});
      step();
    end
    c_in_valid = 3'b000;
    step();
    step();
    chk("c_queue_empty", qc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
